// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch controller.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_e;
  localparam int FETCH_DEPTH = 2;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry synchronous FIFO of fetched {pc, inst}; clear beats push/pop.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);
  fetch_entry_t mem_q [FETCH_DEPTH];
  logic         wr_q, rd_q;
  logic [1:0]   count_q;
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= data_i;
      wr_q    <= wr_q ^ push_i;
      rd_q    <= rd_q ^ pop_i;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: turns the PC into req/ack memory fetches, buffers results for IF/ID
// and stalls the PC until a fetch completes or a redirect is taken.
module ifetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  input  logic        id_stall_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        pc_stall_o
);
  fetch_state_e state_q, state_d;
  logic         pend_q, pend_d;
  logic [31:0]  addr_q, addr_d, drain_addr_q, drain_addr_d;
  logic [1:0]   count;
  fetch_entry_t head;
  logic         launch, complete;
  // A held request keeps its own address so it cannot move even if pc_i does.
  assign launch       = rst_i && state_q != DRAIN && !pend_q && start_i && !flush_i &&
                        count < 2'(FETCH_DEPTH);
  assign mem_req_o    = state_q == DRAIN || pend_q || launch;
  assign mem_addr_o   = state_q == DRAIN ? drain_addr_q : pend_q ? addr_q : launch ? pc_i : '0;
  assign complete     = state_q != DRAIN && mem_req_o && mem_ack_i && !flush_i;
  assign pc_stall_o   = !(flush_i || complete);
  assign inst_valid_o = count != '0;
  assign inst_o       = inst_valid_o ? head.inst : NOP_INST;
  assign inst_pc_o    = inst_valid_o ? head.pc : '0;
  fetch_buf u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (complete),
    .pop_i   (inst_valid_o && !id_stall_i),
    .data_i  ('{pc: mem_addr_o, inst: mem_rdata_i}),
    .head_o  (head),
    .count_o (count)
  );
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    addr_d       = addr_q;
    drain_addr_d = drain_addr_q;
    if (flush_i) begin
      pend_d       = 1'b0;
      state_d      = (mem_req_o && !mem_ack_i) ? DRAIN : IDLE;
      drain_addr_d = (mem_req_o && !mem_ack_i) ? mem_addr_o : drain_addr_q;
    end else if (state_q == DRAIN) begin
      state_d = mem_ack_i ? IDLE : DRAIN;
    end else if (mem_req_o) begin
      pend_d  = !mem_ack_i;
      addr_d  = mem_addr_o;
      state_d = (!mem_ack_i || start_i) ? FETCH : IDLE;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      addr_q       <= '0;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      addr_q       <= addr_d;
      drain_addr_q <= drain_addr_d;
    end
  end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: scoreboard bench with a variable-latency memory and PC model.
module tb_ifetch_ctrl;
  import fetch_pkg::*;
  logic        clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, flush_i = 1'b0, id_stall_i = 1'b0;
  logic [31:0] pc_i = '0, mem_addr_o, mem_rdata_i = '0, inst_o, inst_pc_o;
  logic        mem_req_o, mem_ack_i = 1'b0, inst_valid_o, pc_stall_o;
  ifetch_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i), .flush_i(flush_i),
    .id_stall_i(id_stall_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o), .pc_stall_o(pc_stall_o)
  );
  always #5 clk_i = ~clk_i;
  int           n_chk = 0, n_err = 0, ack_delay = 0, wait_cnt = 0, pops = 0, run = 0;
  logic [31:0]  pc_q = '0, redirect = '0, prev_addr = '0;
  logic         in_drain = 1'b0, prev_hold = 1'b0, done_fetch;
  logic         s_req, s_ack, s_stall, s_valid;
  logic [31:0]  s_addr, s_pc, s_inst;
  fetch_entry_t exp_q[$];
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask
  // One clock cycle: inputs already set just after the rising edge.
  task automatic step();
    pc_i = pc_q;
    #1;
    mem_ack_i   = mem_req_o && wait_cnt >= ack_delay;
    mem_rdata_i = mem_req_o ? inst_of(mem_addr_o) : '0;
    @(negedge clk_i);
    s_req = mem_req_o; s_addr = mem_addr_o; s_ack = mem_ack_i; s_stall = pc_stall_o;
    s_valid = inst_valid_o; s_pc = inst_pc_o; s_inst = inst_o;
    chk("valid", 32'(s_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() == 0) begin
      chk("nop_inst", s_inst, NOP_DEFAULT);
      chk("nop_pc", s_pc, 32'h0);
    end else begin
      chk("head_pc", s_pc, exp_q[0].pc);
      chk("head_inst", s_inst, exp_q[0].inst);
      if (!id_stall_i) begin
        void'(exp_q.pop_front());
        pops++;
      end
    end
    if (prev_hold) begin
      chk("hold_req", 32'(s_req), 32'h1);
      chk("hold_addr", s_addr, prev_addr);
    end else if (s_req && !in_drain) chk("launch_addr", s_addr, pc_q);
    done_fetch = s_req && s_ack && !in_drain && !flush_i;
    chk("pc_stall", 32'(s_stall), 32'(!(flush_i || done_fetch)));
    if (flush_i) begin
      exp_q.delete();
      in_drain = s_req && !s_ack;
    end else begin
      if (done_fetch) exp_q.push_back('{pc: pc_q, inst: inst_of(pc_q)});
      if (s_ack) in_drain = 1'b0;
    end
    prev_hold = s_req && !s_ack;
    prev_addr = s_addr;
    @(posedge clk_i);
    wait_cnt = (s_req && !s_ack) ? wait_cnt + 1 : 0;
    if (!s_stall) pc_q = flush_i ? redirect : pc_q + 32'd4;
    #1;
  endtask
  task automatic settle();
    start_i = 1'b0; id_stall_i = 1'b0; flush_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!s_req && exp_q.size() == 0) break;
    end
    chk("settle_req", 32'(s_req), 32'h0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    start_i = 1'b1;
    #12;
    chk("rst_req", 32'(mem_req_o), 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_inst", inst_o, NOP_DEFAULT);
    chk("rst_pc", inst_pc_o, 32'h0);
    chk("rst_valid", 32'(inst_valid_o), 32'h0);
    chk("rst_stall", 32'(pc_stall_o), 32'h1);
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i) #1;
    // zero-wait memory streaming
    step(); chk("z_req0", 32'(s_req), 32'h1); chk("z_valid0", 32'(s_valid), 32'h0);
    step(); chk("z_pc0", s_pc, 32'h0);
    step(); chk("z_pc4", s_pc, 32'h4);
    step(); chk("z_pc8", s_pc, 32'h8);
    pops = 0;
    for (int i = 0; i < 6; i++) step();
    chk("z_thru", 32'(pops), 32'd6);
    // ID hold fills the queue, then stops requesting
    id_stall_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("full_req", 32'(s_req), 32'h0);
    chk("full_valid", 32'(s_valid), 32'h1);
    id_stall_i = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("resume_req", 32'(s_req), 32'h1);
    // 3-cycle ack latency
    settle();
    pc_q = 32'h10; ack_delay = 3; start_i = 1'b1; run = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_req && s_addr == 32'h10) run++;
      if (s_ack) break;
    end
    chk("lat_run", 32'(run), 32'd4);
    // flush while 0x20 pending, then drain
    settle();
    pc_q = 32'h20; ack_delay = 3; start_i = 1'b1;
    step(); chk("fl_launch", s_addr, 32'h20);
    flush_i = 1'b1; redirect = 32'h100;
    step(); chk("fl_pend", s_addr, 32'h20); chk("fl_noack", 32'(s_ack), 32'h0);
    flush_i = 1'b0;
    step(); chk("dr_addr", s_addr, 32'h20); chk("dr_stall", 32'(s_stall), 32'h1);
    step(); chk("dr_ack", 32'(s_ack), 32'h1); chk("dr_addr2", s_addr, 32'h20);
    ack_delay = 0;
    step(); chk("redir_addr", s_addr, 32'h100); chk("redir_req", 32'(s_req), 32'h1);
    step(); chk("redir_pc", s_pc, 32'h100);
    // flush coinciding with an ack while the queue holds an entry
    settle();
    ack_delay = 1; id_stall_i = 1'b1; start_i = 1'b1;
    step(); step(); step();
    flush_i = 1'b1; redirect = 32'h200;
    step(); chk("fa_ack", 32'(s_ack), 32'h1); chk("fa_valid", 32'(s_valid), 32'h1);
    flush_i = 1'b0; start_i = 1'b0;
    step(); chk("fa_empty", 32'(s_valid), 32'h0); chk("fa_idle", 32'(s_req), 32'h0);
    chk("fa_pc", pc_q, 32'h200);
    // asynchronous reset during a pending request
    ack_delay = 0; start_i = 1'b1; id_stall_i = 1'b1;
    step();
    ack_delay = 5;
    step(); step();
    #2 rst_i = 1'b0;
    #1;
    chk("ar_req", 32'(mem_req_o), 32'h0);
    chk("ar_addr", mem_addr_o, 32'h0);
    chk("ar_valid", 32'(inst_valid_o), 32'h0);
    chk("ar_inst", inst_o, NOP_DEFAULT);
    chk("ar_stall", 32'(pc_stall_o), 32'h1);
    exp_q.delete(); in_drain = 1'b0; prev_hold = 1'b0; wait_cnt = 0;
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i) #1;
    ack_delay = 0; id_stall_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("ar_resume", 32'(s_valid), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
